noc_local_tx: RTL

Credit-based flit transmitter that drives one router input port (valid/data forward, credit return backward). It buffers 16-bit flits from a local source in a small FIFO. A flit is forwarded only while a downstream credit is held. It sits between a core/traffic generator and the router's local (or any directional) input port.

---
 rtl/noc_pkg.sv | 17 +
 rtl/noc_sync_fifo.sv | 66 ++++++
 rtl/noc_local_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit type, local transmitter state
// encoding and default buffer/credit depths.
package noc_pkg;

   localparam int DATA_W    = 16;
   localparam int CREDITS   = 4;
   localparam int BUF_DEPTH = 4;

   typedef logic [DATA_W-1:0] flit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      STALL = 2'd2
   } tx_state_e;

endpackage : noc_pkg

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with registered occupancy count. Push is ignored when
// full and pop is ignored when empty. DEPTH must be a power of two >= 2
// so the pointers wrap naturally.
module noc_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Next storage, pointer and count values.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // State registers; reset empties the FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule : noc_sync_fifo

// File: rtl/noc_local_tx.sv
// Credit-based flit transmitter feeding one router input port.
// Flits from a local source are buffered in noc_sync_fifo and forwarded one
// per cycle while a downstream credit is held; credit_i returns credits.
// Optional macro NOC_TX_CREDIT_CHECK_EN adds a sticky err_o output and an
// assertion for credit overflow / underflow.
//
// Handshakes: the source transfers a flit on an edge where
// src_valid_i && src_ready_o; valid_o is a one-cycle pulse per flit with no
// backpressure, flow control being carried by credits only.
module noc_local_tx #(
   parameter int DATA_W    = noc_pkg::DATA_W,
   parameter int BUF_DEPTH = noc_pkg::BUF_DEPTH,
   parameter int CREDITS   = noc_pkg::CREDITS,
   parameter int CNT_W     = $clog2(CREDITS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              src_valid_i,
   input  logic [DATA_W-1:0] src_data_i,
   output logic              src_ready_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              credit_i,
   output logic [CNT_W-1:0]  credit_cnt_o,
   output logic              idle_o
`ifdef NOC_TX_CREDIT_CHECK_EN
   ,
   output logic              err_o
`endif
);

   import noc_pkg::*;

   localparam int FIFO_CW = $clog2(BUF_DEPTH + 1);

   logic [DATA_W-1:0]  head;
   logic               fifo_full, fifo_empty;
   logic [FIFO_CW-1:0] fifo_count, fifo_count_nx;
   logic               push, send;
   logic               cnt_full;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               idle_q, idle_d;
   tx_state_e          state_q, state_d;

   noc_sync_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (src_data_i),
      .pop_i   (send),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign src_ready_o = !fifo_full;
   assign push        = src_valid_i && !fifo_full;
   // Sends are judged on the registered count, so a credit arriving at
   // count 0 can only be spent on the following edge.
   assign send        = !fifo_empty && (cnt_q != '0);
   assign cnt_full    = (cnt_q == CNT_W'(CREDITS));

   // Credit count, output flit register, idle flag and FSM next state.
   always_comb begin
      cnt_d   = cnt_q;
      valid_d = send;
      data_d  = data_q;
      state_d = state_q;

      if (send) data_d = head;

      unique case ({send, credit_i})
         2'b10:   cnt_d = cnt_q - 1'b1;
         2'b01:   cnt_d = cnt_full ? cnt_q : cnt_q + 1'b1;
         default: cnt_d = cnt_q;
      endcase

      fifo_count_nx = fifo_count + FIFO_CW'(push) - FIFO_CW'(send);
      idle_d = (fifo_count_nx == '0) && !valid_d && (cnt_d == CNT_W'(CREDITS));

      // The state tracks what the send rule will do on the next edge.
      case (state_q)
         IDLE: begin
            if (fifo_count_nx != '0) state_d = (cnt_d != '0) ? SEND : STALL;
         end
         SEND: begin
            if (fifo_count_nx == '0) state_d = IDLE;
            else if (cnt_d == '0)    state_d = STALL;
         end
         STALL: begin
            if (fifo_count_nx == '0) state_d = IDLE;
            else if (cnt_d != '0)    state_d = SEND;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registers; reset restores full credits and an empty, idle transmitter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= CNT_W'(CREDITS);
         valid_q <= 1'b0;
         data_q  <= '0;
         idle_q  <= 1'b1;
         state_q <= IDLE;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         idle_q  <= idle_d;
         state_q <= state_d;
      end
   end

   assign valid_o      = valid_q;
   assign data_o       = data_q;
   assign credit_cnt_o = cnt_q;
   assign idle_o       = idle_q;

`ifdef NOC_TX_CREDIT_CHECK_EN
   logic err_q, err_d;

   // Sticky protocol error: credit overflow or a send without credit.
   always_comb begin
      err_d = err_q | (credit_i && cnt_full) | (send && (cnt_q == '0));
   end

   // Error flag register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err_o = err_q;

   a_credit_ok: assert property (@(posedge clk) disable iff (reset)
      !((credit_i && cnt_full) || (send && (cnt_q == '0))));
`endif

endmodule : noc_local_tx
